tx: RTL and testbench

Output-port transmitter for the NoC router. It is the stage directly downstream of the input-port receiver. It accepts a switch request from a receiver holding an assembled packet and grants it. It then reads the packet flit by flit out of the receiver's buffer and serialises the flits onto the outgoing link using the two-phase (toggle) req/ack channel protocol that receivers expect on their input side.

---
 rtl/tx_if.sv | 34 +++
 rtl/tx.sv | 93 +++++++++
 tb/tb_tx.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_if.sv
// Transmitter-facing bundle: switch request/grant and buffer read port toward the receiver,
// toggle req/ack link toward the downstream receiver, plus a registered debug event strobe.
interface tx_if #(
  parameter int SIZE      = 8,
  parameter int BUFF_BITS = 3
);
  logic                 sw_req;
  logic                 sw_gnt;
  logic [BUFF_BITS-1:0] buf_addr;
  logic [SIZE-1:0]      buf_data;
  logic                 ch_req;
  logic [SIZE-1:0]      ch_flit;
  logic                 ch_ack;
  logic [15:0]          flits_sent;
  // one-cycle debug pulse: dbg_evt 0 = grant, 1 = flit sent, 2 = packet complete
  logic                 dbg_vld;
  logic [1:0]           dbg_evt;
  logic [BUFF_BITS-1:0] dbg_idx;
  logic                 dbg_nohead;
  logic [7:0]           dbg_inst;
  logic [63:0]          dbg_name;

  modport master (
    input  sw_req, buf_data, ch_ack,
    output sw_gnt, buf_addr, ch_req, ch_flit, flits_sent,
           dbg_vld, dbg_evt, dbg_idx, dbg_nohead, dbg_inst, dbg_name
  );

  modport slave (
    output sw_req, buf_data, ch_ack,
    input  sw_gnt, buf_addr, ch_req, ch_flit, flits_sent,
           dbg_vld, dbg_evt, dbg_idx, dbg_nohead, dbg_inst, dbg_name
  );
endinterface

// File: rtl/tx.sv
// NoC output-port transmitter: grants a receiver's packet, then streams 2**BUFF_BITS flits over a toggle req/ack link.
// Grant one edge after sw_req; first flit two edges after sw_req drops; each flit held until ch_ack == ch_req (>= 2 cycles/flit).
module tx #(
  parameter int          ID        = 0,
  parameter logic [63:0] MOD_NAME  = "TX",
  parameter int          SIZE      = 8,
  parameter int          BUFF_BITS = 3
) (
  input  logic  clk,
  input  logic  reset,
  tx_if.master  bus
);
  localparam logic [BUFF_BITS-1:0] LAST_IDX  = {BUFF_BITS{1'b1}};
  localparam logic [1:0]           EVT_GRANT = 2'd0;
  localparam logic [1:0]           EVT_FLIT  = 2'd1;
  localparam logic [1:0]           EVT_DONE  = 2'd2;

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, WAIT_ACK, DONE} state_t;

  state_t               state;
  logic [BUFF_BITS-1:0] idx;
  logic [15:0]          sent_cnt;

  assign bus.flits_sent = sent_cnt;
  assign bus.dbg_inst   = 8'(ID);
  assign bus.dbg_name   = MOD_NAME;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      idx            <= '0;
      sent_cnt       <= '0;
      bus.sw_gnt     <= 1'b0;
      bus.buf_addr   <= '0;
      bus.ch_req     <= 1'b0;
      bus.ch_flit    <= '0;
      bus.dbg_vld    <= 1'b0;
      bus.dbg_evt    <= EVT_GRANT;
      bus.dbg_idx    <= '0;
      bus.dbg_nohead <= 1'b0;
    end else begin
      bus.dbg_vld    <= 1'b0;
      bus.dbg_nohead <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sw_req) begin
            bus.sw_gnt  <= 1'b1;
            state       <= GRANT;
            bus.dbg_vld <= 1'b1;
            bus.dbg_evt <= EVT_GRANT;
          end
        end
        // the receiver dropping sw_req is its acknowledgement of the grant
        GRANT: begin
          if (!bus.sw_req) begin
            bus.buf_addr <= '0;
            state        <= LOAD;
          end
        end
        // a missing head flit is only flagged; the flit is still sent
        LOAD: begin
          bus.ch_flit    <= bus.buf_data;
          bus.ch_req     <= ~bus.ch_req;
          state          <= WAIT_ACK;
          bus.dbg_vld    <= 1'b1;
          bus.dbg_evt    <= EVT_FLIT;
          bus.dbg_idx    <= idx;
          bus.dbg_nohead <= (idx == '0) && !bus.buf_data[SIZE-1];
        end
        WAIT_ACK: begin
          if (bus.ch_ack == bus.ch_req) begin
            sent_cnt <= sent_cnt + 16'd1;
            if (idx != LAST_IDX) begin
              bus.buf_addr <= bus.buf_addr + 1'b1;
              idx          <= idx + 1'b1;
              state        <= LOAD;
            end else begin
              bus.sw_gnt   <= 1'b0;
              idx          <= '0;
              bus.buf_addr <= '0;
              state        <= DONE;
              bus.dbg_vld  <= 1'b1;
              bus.dbg_evt  <= EVT_DONE;
            end
          end
        end
        // one dead cycle keeps sw_gnt low before any re-grant
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx.sv
// Bench for tx: receiver-buffer and link-partner model with per-cycle scoreboard plus literal anchors.
module tb_tx;
  localparam int SIZE      = 8;
  localparam int BUFF_BITS = 3;
  localparam int NFLIT     = 8;

  typedef struct {
    logic [63:0] data;  // flit 0 in bits 63:56
    int          dly;   // ack delay in cycles after a toggle; <0 means random 0..3 per flit
    int          gap;   // idle cycles before requesting
  } pkt_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tx_if #(.SIZE(SIZE), .BUFF_BITS(BUFF_BITS)) bus();

  tx #(.ID(0), .MOD_NAME("TX"), .SIZE(SIZE), .BUFF_BITS(BUFF_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] flit_of(input logic [63:0] d, input logic [2:0] i);
    return d[8*(7-int'(i)) +: 8];
  endfunction

  logic [63:0] cur_data = '0;
  assign bus.buf_data = flit_of(cur_data, bus.buf_addr);

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // model and environment state
  pkt_t        pkt_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] model_sent = '0;
  logic        gnt_exp = 1'b0;
  int          cool = 0;
  int          pkt_acks = 0;
  bit          ack_armed = 0;
  bit          waiting = 0;
  int          wait_cnt = 0;
  int          cur_dly = 0;
  logic        prev_req = 1'b0;
  logic [7:0]  prev_flit = '0;
  int          cyc = 0;
  int          next_tog = -1;
  bit          busy = 0;
  int          gap_cnt = -1;
  logic [63:0] cap_word = '0;
  int          first_tog_cyc = 0;
  int          pkt_cycles = 0;
  logic        first_tog_val = 1'b0;
  int          low_run = 0;
  int          last_low_run = 0;
  int          pkts_done = 0;
  int          nohead_seen = 0;

  // single environment/compare process, everything on the falling edge
  initial begin
    pkt_t p;
    bus.sw_req = 1'b0;
    bus.ch_ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        model_sent = '0; gnt_exp = 1'b0; cool = 0; pkt_acks = 0;
        ack_armed = 0; waiting = 0; next_tog = -1;
        prev_req = 1'b0; prev_flit = '0;
        bus.ch_ack = 1'b0;
        if (!(busy && bus.sw_req)) begin
          exp_q.delete(); busy = 0; bus.sw_req = 1'b0; gap_cnt = -1;
        end
        check("rst_sw_gnt", bus.sw_gnt, 0);
        check("rst_ch_req", bus.ch_req, 0);
        check("rst_ch_flit", bus.ch_flit, 0);
        check("rst_flits_sent", bus.flits_sent, 0);
        check("rst_buf_addr", bus.buf_addr, 0);
      end else begin
        // what the rising edge just passed must have done
        if (ack_armed) begin
          ack_armed = 0;
          model_sent++;
          pkt_acks++;
          if (pkt_acks == NFLIT) begin
            gnt_exp = 1'b0; cool = 1; pkt_acks = 0; busy = 0;
            pkt_cycles = cyc - first_tog_cyc + 1;
            low_run = 0;
            pkts_done++;
          end
        end else if (!gnt_exp) begin
          if (cool > 0) cool--;
          else if (bus.sw_req) begin
            gnt_exp = 1'b1; last_low_run = low_run; low_run = 0;
          end
        end
        if (!gnt_exp) low_run++;

        check("sw_gnt", bus.sw_gnt, gnt_exp);
        check("flits_sent", bus.flits_sent, model_sent);
        if (bus.ch_req !== prev_req) begin
          check("toggle_time", cyc, next_tog);
          if (exp_q.size() > 0) check("ch_flit", bus.ch_flit, exp_q.pop_front());
          next_tog = -1;
          if (pkt_acks == 0) begin
            first_tog_cyc = cyc; first_tog_val = bus.ch_req; cap_word = '0;
          end
          cap_word = {cap_word[55:0], bus.ch_flit};
          waiting = 1;
          wait_cnt = (cur_dly < 0) ? int'($urandom_range(3)) : cur_dly;
        end else begin
          check("flit_stable", bus.ch_flit, prev_flit);
        end
        prev_req = bus.ch_req;
        prev_flit = bus.ch_flit;

        // link partner
        if (waiting) begin
          if (wait_cnt == 0) begin
            waiting = 0;
            bus.ch_ack = bus.ch_req;
            ack_armed = 1;
            if (pkt_acks < NFLIT-1) next_tog = cyc + 2;
          end else begin
            wait_cnt--;
          end
        end
        // receiver acknowledges the grant by dropping its request
        if (bus.sw_req && bus.sw_gnt === 1'b1) begin
          bus.sw_req = 1'b0;
          next_tog = cyc + 2;
        end
      end

      if (!busy && pkt_q.size() > 0) begin
        if (gap_cnt < 0) gap_cnt = pkt_q[0].gap;
        if (gap_cnt > 0) gap_cnt--;
        else begin
          p = pkt_q.pop_front();
          cur_data = p.data; cur_dly = p.dly; busy = 1; gap_cnt = -1;
          bus.sw_req = 1'b1;
          for (int i = 0; i < NFLIT; i++) exp_q.push_back(flit_of(p.data, 3'(i)));
        end
      end
    end
  end

  // debug message printer
  always @(negedge clk) begin
    if (reset && bus.dbg_vld) begin
      case (bus.dbg_evt)
        2'd0: $display("[%s%0d] grant", bus.dbg_name, bus.dbg_inst);
        2'd1: begin
          if (bus.dbg_nohead) begin
            nohead_seen++;
            $display("[%s%0d] missing head flit", bus.dbg_name, bus.dbg_inst);
          end
          $display("[%s%0d] flit %0d = 0x%02h", bus.dbg_name, bus.dbg_inst, bus.dbg_idx, bus.ch_flit);
        end
        default: $display("[%s%0d] packet complete", bus.dbg_name, bus.dbg_inst);
      endcase
    end
  end

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkts_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("pkts_done", pkts_done, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t, required finish before 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    pkt_t p;
    int   n;
    // reset held with a request already pending
    p.data = 64'h8001020304050607; p.dly = 0; p.gap = 0;
    pkt_q.push_back(p);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("no_grant_in_reset", bus.sw_gnt, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("grant_after_release", bus.sw_gnt, 1);
    wait_pkts(1, 200);
    check("pkt0_flits", cap_word, 64'h8001020304050607);
    check("pkt0_sent", bus.flits_sent, 8);
    check("pkt0_cycles", pkt_cycles, 16);

    // slow responder
    p.data = 64'h9A5A3C0FF0C3A596; p.dly = 4; p.gap = 2;
    pkt_q.push_back(p);
    wait_pkts(2, 400);
    check("slow_cycles", pkt_cycles, 48);
    check("slow_sent", bus.flits_sent, 16);

    // back-to-back, second request raised during DONE
    p.data = 64'hC011223344556677; p.dly = 0; p.gap = 0;
    pkt_q.push_back(p);
    p.data = 64'hD18899AABBCCDDEE;
    pkt_q.push_back(p);
    wait_pkts(4, 400);
    check("b2b_sent", bus.flits_sent, 32);
    check("b2b_gnt_low", last_low_run, 2);
    check("b2b_first_phase", first_tog_val, 1);
    check("b2b_flits", cap_word, 64'hD18899AABBCCDDEE);

    // randomized traffic
    for (int k = 0; k < 20; k++) begin
      p.data = {$urandom, $urandom};
      p.data[63] = 1'b1;
      p.dly = (k % 3 == 0) ? -1 : int'($urandom_range(2));
      p.gap = int'($urandom_range(3));
      pkt_q.push_back(p);
    end
    wait_pkts(24, 4000);
    check("rand_sent", bus.flits_sent, 24 * 8);

    // reset in the middle of a packet
    p.data = 64'hE0E1E2E3E4E5E6E7; p.dly = 0; p.gap = 0;
    pkt_q.push_back(p);
    n = 0;
    while (pkt_acks < 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("mid_ack_reached", pkt_acks >= 3, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_sw_gnt", bus.sw_gnt, 0);
    check("mid_rst_ch_req", bus.ch_req, 0);
    check("mid_rst_ch_flit", bus.ch_flit, 0);
    check("mid_rst_sent", bus.flits_sent, 0);
    check("mid_rst_addr", bus.buf_addr, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    p.data = 64'hF7F6F5F4F3F2F1F0; p.dly = 1; p.gap = 0;
    pkt_q.push_back(p);
    wait_pkts(25, 400);
    check("post_rst_flits", cap_word, 64'hF7F6F5F4F3F2F1F0);
    check("post_rst_sent", bus.flits_sent, 8);
    check("post_rst_phase", first_tog_val, 1);

    // counter wrap, with a packet lacking its head flag
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    force dut.sent_cnt = 16'hFFF8;
    model_sent = 16'hFFF8;
    #1;
    release dut.sent_cnt;
    p.data = 64'h0511223344556677; p.dly = 1; p.gap = 1;
    pkt_q.push_back(p);
    wait_pkts(26, 400);
    check("wrap_sent", bus.flits_sent, 16'h0000);
    check("wrap_flits", cap_word, 64'h0511223344556677);
    check("nohead_notices", nohead_seen, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
